// File: rtl/game_pkg.sv
// Purpose: shared types and defaults for the reaction game input front end.
// Contents: reaction FSM state encoding, the start word written to $r1,
//           and default timing/width parameters.
package game_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_HOLD_CYCLES     = 64;
  localparam int unsigned DEF_CNT_W           = 8;

  localparam logic [31:0] START_WORD = 32'd1;

  typedef enum logic [2:0] {
    ARM,
    IDLE,
    FIRE,
    WAIT_REL,
    LOCKED
  } react_state_t;

endpackage

// File: rtl/debounce_filter.sv
// Purpose: two-flop synchroniser followed by a stability counter that
//          produces a clean debounced level for one push-button.
// Ports:
//   clock      in   system clock, rising edge
//   ctrl_reset in   synchronous active-high reset
//   raw        in   asynchronous button input, active high
//   level      out  debounced level (registered)
//   rise_c     out  combinational strobe: level goes 0->1 on the next edge
//   settled_c  out  combinational: synchroniser primed and synced input
//                   agrees with the debounced level (nothing pending)
module debounce_filter
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic ctrl_reset,
  input  logic raw,
  output logic level,
  output logic rise_c,
  output logic settled_c
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [1:0]    primed;
  logic [CW-1:0] cnt;
  logic          toggle_c;

  // Level flips on the edge after the counter has reached the threshold.
  assign toggle_c  = (sync2 != level) && (cnt == CW'(DEBOUNCE_CYCLES));
  assign rise_c    = toggle_c & ~level;
  // primed[1] marks that sync2 carries a post-reset sample of raw.
  assign settled_c = primed[1] && (sync2 == level);

  // Synchroniser, priming shift register and stability counter.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      primed <= 2'b00;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      primed <= {primed[0], 1'b1};
      if (sync2 == level) begin
        cnt <= '0;
      end else if (toggle_c) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/reaction_input_conditioner.sv
// Purpose: front end for the reaction game. Debounces the reaction and
//          start buttons, emits one fixed-width playerReaction pulse per
//          press, drives the start word for $r1 and locks out all input
//          once the game result is known.
// Ports:
//   clock          in   system clock, rising edge
//   ctrl_reset     in   synchronous active-high reset
//   btn_react_raw  in   asynchronous reaction button, active high
//   btn_start_raw  in   asynchronous start button, active high
//   game_over      in   winSignal | loseSignal
//   playerReaction out  registered reaction pulse, HOLD_CYCLES wide
//   r1_in          out  0 before start, START_WORD after accepted start
//   react_count    out  accepted presses since reset, saturating
module reaction_input_conditioner
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             btn_react_raw,
  input  logic             btn_start_raw,
  input  logic             game_over,
  output logic             playerReaction,
  output logic [31:0]      r1_in,
  output logic [CNT_W-1:0] react_count
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  react_state_t     state;
  react_state_t     state_next;
  logic [HW-1:0]    hold;
  logic [HW-1:0]    hold_next;
  logic [CNT_W-1:0] count_next;
  logic             pr_next;
  logic [31:0]      r1_next;
  logic             start_armed;
  logic             armed_next;

  logic r_level;
  logic r_settled_c;
  logic unused_react_rise;
  logic s_level;
  logic s_rise_c;
  logic s_settled_c;

  // Reaction channel: FSM works from the debounced level, not the strobe.
  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_react_filter (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .raw       (btn_react_raw),
    .level     (r_level),
    .rise_c    (unused_react_rise),
    .settled_c (r_settled_c)
  );

  // Start channel: the rise strobe lets r1_in update on the same edge
  // the debounced level rises.
  debounce_filter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_filter (
    .clock     (clock),
    .ctrl_reset(ctrl_reset),
    .raw       (btn_start_raw),
    .level     (s_level),
    .rise_c    (s_rise_c),
    .settled_c (s_settled_c)
  );

  // State and output registers.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      state          <= ARM;
      hold           <= '0;
      playerReaction <= 1'b0;
      react_count    <= '0;
      r1_in          <= '0;
      start_armed    <= 1'b0;
    end else begin
      state          <= state_next;
      hold           <= hold_next;
      playerReaction <= pr_next;
      react_count    <= count_next;
      r1_in          <= r1_next;
      start_armed    <= armed_next;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next = state;
    hold_next  = hold;
    count_next = react_count;
    r1_next    = r1_in;
    armed_next = start_armed | (s_settled_c & ~s_level);
    pr_next    = 1'b0;

    case (state)
      // Only leave once a post-reset sample shows the button released,
      // so a press held through reset cannot fire.
      ARM: begin
        if (!r_level && r_settled_c) begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (r_level) begin
          state_next = FIRE;
          hold_next  = HW'(HOLD_CYCLES - 1);
          count_next = (&react_count) ? react_count : react_count + CNT_W'(1);
        end
      end
      FIRE: begin
        if (hold == '0) begin
          state_next = r_level ? WAIT_REL : IDLE;
        end else begin
          hold_next = hold - HW'(1);
        end
      end
      WAIT_REL: begin
        if (!r_level) begin
          state_next = IDLE;
        end
      end
      LOCKED: begin
        state_next = LOCKED;
      end
      default: begin
        state_next = ARM;
      end
    endcase

    // Game result overrides any press detected in the same cycle.
    if (game_over) begin
      state_next = LOCKED;
      hold_next  = hold;
      count_next = react_count;
    end

    pr_next = (state_next == FIRE);

    if (s_rise_c && start_armed && !game_over) begin
      r1_next = START_WORD;
    end
  end

endmodule

// File: tb/tb_reaction_input_conditioner.sv
module tb_reaction_input_conditioner;

  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 3;
  localparam int unsigned CW   = 3;

  logic          clock = 1'b0;
  logic          ctrl_reset = 1'b1;
  logic          btn_react_raw = 1'b0;
  logic          btn_start_raw = 1'b0;
  logic          game_over = 1'b0;
  logic          playerReaction;
  logic [31:0]   r1_in;
  logic [CW-1:0] react_count;

  typedef struct {
    int edge_no;
    int count;
    int width;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  reaction_input_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .CNT_W          (CW)
  ) dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .btn_react_raw (btn_react_raw),
    .btn_start_raw (btn_start_raw),
    .game_over     (game_over),
    .playerReaction(playerReaction),
    .r1_in         (r1_in),
    .react_count   (react_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Pulse monitor: pops the scoreboard at each rising pulse.
  logic pr_q = 1'b0;
  exp_t cur;
  bit   have_cur = 1'b0;
  int   width = 0;

  always @(negedge clock) begin
    if (playerReaction === 1'b1 && pr_q == 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("spurious_pulse_edge", 32'(cyc), 32'hFFFF_FFFF);
        have_cur = 1'b0;
      end else begin
        cur = exp_q.pop_front();
        have_cur = 1'b1;
        chk("pulse_edge", 32'(cyc), 32'(cur.edge_no));
        chk("pulse_count", 32'(react_count), 32'(cur.count));
      end
      width = 0;
    end
    if (playerReaction === 1'b1) begin
      width++;
    end else if (pr_q && have_cur) begin
      chk("pulse_width", 32'(width), 32'(cur.width));
      have_cur = 1'b0;
    end
    pr_q = (playerReaction === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Next edge is edge 0; the pulse rises at edge 3+DEB.
  task automatic press_react(input int hold_n, input int count, input int w);
    exp_t e;
    e.edge_no = cyc + 1 + 3 + int'(DEB);
    e.count   = count;
    e.width   = w;
    exp_q.push_back(e);
    btn_react_raw = 1'b1;
    tick(hold_n);
    btn_react_raw = 1'b0;
    tick(12);
  endtask

  task automatic do_reset();
    ctrl_reset = 1'b1;
    tick(3);
    chk("reset_pr", 32'(playerReaction), 32'd0);
    chk("reset_r1", r1_in, 32'd0);
    chk("reset_count", 32'(react_count), 32'd0);
    ctrl_reset = 1'b0;
    tick(5);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    do_reset();

    // Glitch shorter than the debounce window.
    btn_react_raw = 1'b1;
    tick(3);
    btn_react_raw = 1'b0;
    tick(15);
    chk("glitch_count", 32'(react_count), 32'd0);
    chk("glitch_pr", 32'(playerReaction), 32'd0);

    // Clean press, release, re-press.
    press_react(20, 1, 3);
    chk("press1_seen", 32'(exp_q.size()), 32'd0);
    chk("press1_count", 32'(react_count), 32'd1);
    press_react(20, 2, 3);
    chk("press2_seen", 32'(exp_q.size()), 32'd0);
    chk("press2_count", 32'(react_count), 32'd2);

    // Bouncy press: dropouts every third cycle, then stable.
    for (int i = 0; i < 15; i++) begin
      btn_react_raw = (i % 3 != 2);
      tick(1);
    end
    press_react(20, 3, 3);
    chk("bounce_seen", 32'(exp_q.size()), 32'd0);
    chk("bounce_count", 32'(react_count), 32'd3);

    // Button held across reset deassert.
    btn_react_raw = 1'b1;
    do_reset();
    tick(20);
    chk("held_no_pulse_count", 32'(react_count), 32'd0);
    btn_react_raw = 1'b0;
    tick(12);
    press_react(12, 1, 3);
    chk("after_held_count", 32'(react_count), 32'd1);

    // Start press: r1_in updates at edge 6.
    btn_start_raw = 1'b1;
    tick(6);
    chk("start_r1_edge5", r1_in, 32'd0);
    tick(1);
    chk("start_r1_edge6", r1_in, 32'd1);
    tick(8);
    btn_start_raw = 1'b0;
    tick(12);
    chk("start_r1_released", r1_in, 32'd1);
    btn_start_raw = 1'b1;
    tick(12);
    btn_start_raw = 1'b0;
    tick(12);
    chk("start_r1_second", r1_in, 32'd1);

    // game_over before start locks out both buttons.
    do_reset();
    game_over = 1'b1;
    tick(2);
    btn_start_raw = 1'b1;
    tick(15);
    chk("go_start_r1", r1_in, 32'd0);
    btn_start_raw = 1'b0;
    btn_react_raw = 1'b1;
    tick(15);
    btn_react_raw = 1'b0;
    tick(12);
    chk("go_react_count", 32'(react_count), 32'd0);
    chk("go_react_pr", 32'(playerReaction), 32'd0);
    game_over = 1'b0;

    // game_over raised mid-FIRE.
    do_reset();
    begin
      exp_t e;
      e.edge_no = cyc + 1 + 3 + int'(DEB);
      e.count   = 1;
      e.width   = 1;
      exp_q.push_back(e);
    end
    btn_react_raw = 1'b1;
    tick(8);
    chk("midfire_go_pr_before", 32'(playerReaction), 32'd1);
    game_over = 1'b1;
    tick(1);
    chk("midfire_go_pr_after", 32'(playerReaction), 32'd0);
    game_over = 1'b0;
    tick(10);
    btn_react_raw = 1'b0;
    tick(12);
    btn_react_raw = 1'b1;
    tick(15);
    btn_react_raw = 1'b0;
    tick(12);
    chk("locked_count", 32'(react_count), 32'd1);
    chk("locked_seen", 32'(exp_q.size()), 32'd0);

    // ctrl_reset mid-FIRE, with r1_in already set.
    do_reset();
    btn_start_raw = 1'b1;
    tick(10);
    btn_start_raw = 1'b0;
    tick(12);
    chk("pre_reset_r1", r1_in, 32'd1);
    begin
      exp_t e;
      e.edge_no = cyc + 1 + 3 + int'(DEB);
      e.count   = 1;
      e.width   = 1;
      exp_q.push_back(e);
    end
    btn_react_raw = 1'b1;
    tick(8);
    chk("midfire_rst_pr_before", 32'(playerReaction), 32'd1);
    ctrl_reset = 1'b1;
    tick(1);
    chk("midfire_rst_pr", 32'(playerReaction), 32'd0);
    chk("midfire_rst_r1", r1_in, 32'd0);
    chk("midfire_rst_count", 32'(react_count), 32'd0);
    tick(2);
    ctrl_reset = 1'b0;
    tick(20);
    chk("arm_hold_count", 32'(react_count), 32'd0);
    btn_react_raw = 1'b0;
    tick(12);
    press_react(12, 1, 3);
    chk("arm_release_count", 32'(react_count), 32'd1);

    // Saturation of react_count.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      press_react(12, (i < 7) ? i + 1 : 7, 3);
    end
    chk("sat_count", 32'(react_count), 32'd7);

    chk("all_pulses_seen", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
